hls_mem_driver: RTL and testbench

HLS_MEM_DRIVER -- requirements
Module: hls_mem_driver

---
 rtl/hls_mem_driver.sv | 221 ++++++++++++++++++++++
 tb/tb_hls_mem_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_mem_driver.sv
`timescale 1ns/1ps
// hls_mem_driver: drives an HLS core through repeated start/done runs and
// serves its per-channel memory ports from an internal RAM model.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   run_en                  keep restarting the core after each gap
//   init_we/addr/data       host preload of the RAM (honoured only in IDLE)
//   core_start / core_done  run handshake with the core
//   core_oe/we/addr/wdata   per-channel access requests (core_size ignored)
//   core_rdata/data_rdy     per-channel completion and read data
//   trace_valid/chan/data   write trace (lowest writing channel, low byte)
//   run_count, busy         completed runs, FSM not idle
//   timeout                 sticky watchdog flag
//
// Optional feature: define HLS_MEM_DRIVER_WATCHDOG_EN to enable a 16-bit
// RUN-state watchdog; otherwise timeout is tied low and RUN waits forever.
module hls_mem_driver #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h40000000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RESTART_GAP  = 100
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        run_en,
  input  logic                                        init_we,
  input  logic [$clog2(DEPTH)-1:0]                    init_addr,
  input  logic [DATA_W-1:0]                           init_data,
  output logic                                        core_start,
  input  logic                                        core_done,
  input  logic [CHANNELS-1:0]                         core_oe,
  input  logic [CHANNELS-1:0]                         core_we,
  input  logic [CHANNELS*ADDR_W-1:0]                  core_addr,
  input  logic [CHANNELS*DATA_W-1:0]                  core_wdata,
  output logic [CHANNELS*DATA_W-1:0]                  core_rdata,
  input  logic [CHANNELS*6-1:0]                       core_size,
  output logic [CHANNELS-1:0]                         core_data_rdy,
  output logic                                        trace_valid,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trace_chan,
  output logic [7:0]                                  trace_data,
  output logic [15:0]                                 run_count,
  output logic                                        busy,
  output logic                                        timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SH = $clog2(DATA_W / 8);
  localparam int unsigned PS = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t              state;
  logic [31:0]         countdown;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr     [CHANNELS];
  logic [ADDR_W-1:0]   off      [CHANNELS];
  logic [AW-1:0]       widx     [CHANNELS];
  logic [DATA_W-1:0]   rd_word  [CHANNELS];
  logic [DATA_W-1:0]   tail_dat [CHANNELS];
  logic [CHANNELS-1:0] rd_req, wr_req, in_range, tail_vld;
  logic [CW-1:0]       low_ch;
  logic [7:0]          low_byte;

  // Access size is not modelled; every access is a full word.
  logic unused_size;
  assign unused_size = ^core_size;

  // Address decode; a write wins over a read on the same channel.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      addr[c]     = core_addr[c*ADDR_W +: ADDR_W];
      off[c]      = addr[c] - BASE;
      in_range[c] = (addr[c] >= BASE) && ((off[c] >> SH) < DEPTH_A);
      widx[c]     = off[c][SH +: AW];
      rd_req[c]   = core_oe[c] & ~core_we[c];
      wr_req[c]   = core_we[c];
      rd_word[c]  = in_range[c] ? mem[widx[c]] : '0;
    end
  end

  // Lowest-index writer feeds the trace port.
  always_comb begin
    low_ch   = '0;
    low_byte = '0;
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (wr_req[c]) begin
        low_ch   = CW'(c);
        low_byte = core_wdata[c*DATA_W +: 8];
      end
    end
  end

  // RAM model: no reset so contents survive; later channels override earlier.
  always_ff @(posedge clk) begin
    if (init_we && (state == IDLE)) mem[init_addr] <= init_data;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (wr_req[c] && in_range[c]) mem[widx[c]] <= core_wdata[c*DATA_W +: DATA_W];
    end
  end

  // Read delay line; the output register below is its final stage.
  generate
    if (READ_LATENCY > 1) begin : g_pipe
      logic [CHANNELS-1:0] pv [PS];
      logic [DATA_W-1:0]   pd [PS][CHANNELS];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < int'(PS); k++) pv[k] <= '0;
        end else begin
          pv[0] <= rd_req;
          for (int k = 1; k < int'(PS); k++) pv[k] <= pv[k-1];
        end
        pd[0] <= rd_word;
        for (int k = 1; k < int'(PS); k++) pd[k] <= pd[k-1];
      end

      assign tail_vld = pv[PS-1];
      always_comb tail_dat = pd[PS-1];
    end else begin : g_direct
      assign tail_vld = rd_req;
      always_comb tail_dat = rd_word;
    end
  endgenerate

`ifdef HLS_MEM_DRIVER_WATCHDOG_EN
  logic [15:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  // Run-control FSM plus registered completion and trace outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      countdown     <= '0;
      run_count     <= '0;
      core_start    <= 1'b0;
      busy          <= 1'b0;
      core_data_rdy <= '0;
      core_rdata    <= '0;
      trace_valid   <= 1'b0;
      trace_chan    <= '0;
      trace_data    <= '0;
`ifdef HLS_MEM_DRIVER_WATCHDOG_EN
      wd_cnt        <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
      // Write acks land one cycle after the request, reads after READ_LATENCY.
      core_data_rdy <= tail_vld | wr_req;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        core_rdata[c*DATA_W +: DATA_W] <= tail_vld[c] ? tail_dat[c] : '0;
      end
      trace_valid <= |wr_req;
      trace_chan  <= low_ch;
      trace_data  <= low_byte;

`ifdef HLS_MEM_DRIVER_WATCHDOG_EN
      wd_cnt <= (state == RUN) ? wd_cnt + 16'd1 : '0;
`endif

      case (state)
        IDLE: begin
          if (run_en) begin
            state      <= START;
            core_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        START: begin
          state      <= RUN;
          core_start <= 1'b0;
        end
        RUN: begin
          if (core_done) begin
            state     <= GAP;
            countdown <= 32'(RESTART_GAP);
            run_count <= run_count + 16'd1;
          end
`ifdef HLS_MEM_DRIVER_WATCHDOG_EN
          // 65535th RUN cycle without done: abort the run, count unchanged.
          else if (wd_cnt == 16'hFFFE) begin
            state     <= GAP;
            countdown <= 32'(RESTART_GAP);
            timeout   <= 1'b1;
          end
`endif
        end
        GAP: begin
          // Leave after the cycle in which the countdown reads 1.
          if (countdown < 32'd2) begin
            countdown <= '0;
            if (run_en) begin
              state      <= START;
              core_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            countdown <= countdown - 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_mem_driver.sv
`timescale 1ns/1ps
// Directed bench for hls_mem_driver with READ_LATENCY=3, two channels.
module tb_hls_mem_driver;

  localparam int unsigned RL  = 3;
  localparam int unsigned GAP = 100;

  logic        clk = 1'b0;
  logic        reset, run_en, init_we;
  logic [5:0]  init_addr;
  logic [31:0] init_data;
  logic        core_start, core_done;
  logic [1:0]  core_oe, core_we;
  logic [63:0] core_addr, core_wdata, core_rdata;
  logic [11:0] core_size;
  logic [1:0]  core_data_rdy;
  logic        trace_valid;
  logic [0:0]  trace_chan;
  logic [7:0]  trace_data;
  logic [15:0] run_count;
  logic        busy, timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  hls_mem_driver #(
    .CHANNELS(2), .DATA_W(32), .ADDR_W(32), .DEPTH(64),
    .BASE_ADDR(32'h40000000), .READ_LATENCY(RL), .RESTART_GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .run_en(run_en),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .core_start(core_start), .core_done(core_done),
    .core_oe(core_oe), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_size(core_size),
    .core_data_rdy(core_data_rdy),
    .trace_valid(trace_valid), .trace_chan(trace_chan), .trace_data(trace_data),
    .run_count(run_count), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one read and check the ack lands exactly RL cycles later.
  task automatic read_check(input string tag, input int ch, input logic [31:0] addr,
                            input logic [31:0] exp);
    core_oe[ch] = 1'b1;
    core_addr[ch*32 +: 32] = addr;
    tick();
    core_oe[ch] = 1'b0;
    for (int i = 1; i < int'(RL); i++) begin
      check({tag, "_early"}, 64'(core_data_rdy[ch]), 64'd0);
      tick();
    end
    check({tag, "_rdy"}, 64'(core_data_rdy[ch]), 64'd1);
    check({tag, "_data"}, 64'(core_rdata[ch*32 +: 32]), 64'(exp));
    tick();
    check({tag, "_rdy_off"}, 64'(core_data_rdy[ch]), 64'd0);
    check({tag, "_zero"}, 64'(core_rdata[ch*32 +: 32]), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run_en = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
    core_done = 1'b0; core_oe = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    core_size = 12'hABC;
    tick(); tick();
    check("rst_start", 64'(core_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(run_count), 64'd0);
    check("rst_rdy", 64'(core_data_rdy), 64'd0);
    check("rst_rdata", core_rdata, 64'd0);
    check("rst_trace", 64'(trace_valid), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    reset = 1'b0;

    // Preload in IDLE.
    init_we = 1'b1;
    init_addr = 6'd0;  init_data = 32'h00000080; tick();
    init_addr = 6'd1;  init_data = 32'h0000AAAA; tick();
    init_addr = 6'd2;  init_data = 32'h00005555; tick();
    init_addr = 6'd63; init_data = 32'h12345678; tick();
    init_we = 1'b0;

    // Start a run.
    run_en = 1'b1;
    tick();
    check("start_pulse", 64'(core_start), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    tick();
    check("run_start_low", 64'(core_start), 64'd0);
    check("run_busy", 64'(busy), 64'd1);

    // Preload outside IDLE must be ignored.
    init_we = 1'b1; init_addr = 6'd2; init_data = 32'h0000DEAD; tick();
    init_we = 1'b0;

    read_check("rd_w0", 0, 32'h40000000, 32'h00000080);
    read_check("rd_w63", 1, 32'h400000FC, 32'h12345678);
    read_check("init_ign", 0, 32'h40000008, 32'h00005555);

    // Two channels write one word: ch1 data kept, trace shows ch0.
    core_we = 2'b11;
    core_addr = {32'h40000004, 32'h40000004};
    core_wdata = {32'h00000022, 32'h00000011};
    tick();
    core_we = 2'b00;
    check("wr2_ack", 64'(core_data_rdy), 64'd3);
    check("wr2_rdata0", core_rdata, 64'd0);
    check("wr2_tvalid", 64'(trace_valid), 64'd1);
    check("wr2_tchan", 64'(trace_chan), 64'd0);
    check("wr2_tdata", 64'(trace_data), 64'h11);
    tick();
    check("wr2_ack_off", 64'(core_data_rdy), 64'd0);
    check("wr2_tvalid_off", 64'(trace_valid), 64'd0);
    read_check("wr_win", 0, 32'h40000004, 32'h00000022);

    // Single ch1 write: trace reports ch1.
    core_we = 2'b10; core_addr[63:32] = 32'h40000014; core_wdata[63:32] = 32'hABCDEF99;
    tick();
    core_we = 2'b00;
    check("wr1_tchan", 64'(trace_chan), 64'd1);
    check("wr1_tdata", 64'(trace_data), 64'h99);
    tick();
    read_check("wr1_rd", 0, 32'h40000014, 32'hABCDEF99);

    // Out-of-range reads and a discarded-but-acked write.
    read_check("oor_low", 1, 32'h3FFFFFFC, 32'h0);
    read_check("oor_high", 0, 32'h40000100, 32'h0);
    core_we = 2'b10; core_addr[63:32] = 32'h40000100; core_wdata[63:32] = 32'hFFFFFFFF;
    tick();
    core_we = 2'b00;
    check("oor_wr_ack", 64'(core_data_rdy), 64'd2);
    tick();
    read_check("oor_wr_keep", 0, 32'h40000000, 32'h00000080);

    // oe and we together act as a write only.
    core_oe = 2'b01; core_we = 2'b01; core_addr[31:0] = 32'h4000000C; core_wdata[31:0] = 32'h33;
    tick();
    core_oe = 2'b00; core_we = 2'b00;
    check("oewe_ack", 64'(core_data_rdy), 64'd1);
    tick();
    check("oewe_t2", 64'(core_data_rdy), 64'd0);
    tick();
    check("oewe_no_rd", 64'(core_data_rdy), 64'd0);
    tick();
    read_check("oewe_rd", 1, 32'h4000000C, 32'h00000033);

    // Same-cycle read and write of one word: read sees old data.
    core_oe = 2'b01; core_we = 2'b10;
    core_addr = {32'h40000004, 32'h40000004};
    core_wdata[63:32] = 32'h44;
    tick();
    core_oe = 2'b00; core_we = 2'b00;
    check("rw_wack", 64'(core_data_rdy), 64'd2);
    tick();
    check("rw_t2", 64'(core_data_rdy), 64'd0);
    tick();
    check("rw_rack", 64'(core_data_rdy), 64'd1);
    check("rw_old", 64'(core_rdata[31:0]), 64'h22);
    tick();
    read_check("rw_new", 1, 32'h40000004, 32'h00000044);

    // Back-to-back pipelined reads on ch0.
    core_oe = 2'b01; core_addr[31:0] = 32'h40000000; tick();
    core_addr[31:0] = 32'h40000004; tick();
    core_oe = 2'b00;
    check("pipe_t2", 64'(core_data_rdy), 64'd0);
    tick();
    check("pipe_a_rdy", 64'(core_data_rdy), 64'd1);
    check("pipe_a", 64'(core_rdata[31:0]), 64'h80);
    tick();
    check("pipe_b_rdy", 64'(core_data_rdy), 64'd1);
    check("pipe_b", 64'(core_rdata[31:0]), 64'h44);
    tick();
    check("pipe_off", 64'(core_data_rdy), 64'd0);

    // done -> next start after GAP+1 cycles.
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("gap_count", 64'(run_count), 64'd1);
    check("gap_busy", 64'(busy), 64'd1);
    n = 1;
    while (core_start !== 1'b1 && n < 300) begin tick(); n++; end
    check("gap_restart", 64'(n), 64'(GAP + 1));
    tick();
    check("rerun_start_low", 64'(core_start), 64'd0);

    // done with run_en low -> IDLE after the gap.
    run_en = 1'b0;
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("gap2_count", 64'(run_count), 64'd2);
    n = 1;
    while (busy !== 1'b0 && n < 300) begin tick(); n++; end
    check("gap_to_idle", 64'(n), 64'(GAP + 1));
    check("idle_start", 64'(core_start), 64'd0);

    // Reset one cycle after a read drops it; RAM survives.
    run_en = 1'b1; tick(); tick(); run_en = 1'b0;
    core_oe = 2'b01; core_addr[31:0] = 32'h40000000; tick();
    core_oe = 2'b00; reset = 1'b1; tick(); reset = 1'b0;
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_count", 64'(run_count), 64'd0);
    check("rr_rdy_a", 64'(core_data_rdy), 64'd0);
    tick();
    check("rr_rdy_b", 64'(core_data_rdy), 64'd0);
    tick();
    check("rr_rdy_c", 64'(core_data_rdy), 64'd0);
    check("rr_idle", 64'(busy), 64'd0);
    read_check("rr_ram", 0, 32'h40000000, 32'h00000080);

`ifdef HLS_MEM_DRIVER_WATCHDOG_EN
    run_en = 1'b1; tick(); tick(); run_en = 1'b0;
    repeat (65534) tick();
    check("wd_before", 64'(timeout), 64'd0);
    tick();
    check("wd_timeout", 64'(timeout), 64'd1);
    check("wd_busy", 64'(busy), 64'd1);
    check("wd_count", 64'(run_count), 64'd0);
    check("wd_start", 64'(core_start), 64'd0);
`else
    check("no_wd", 64'(timeout), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
